// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_mode_e   - access mode encoding as presented on req_ctrl
//   lsu_state_e  - LSU control FSM states
//   mode_legal   - 1 for the five defined access modes
//   size_mask    - byte-lane mask for a mode at offset 0 (B/H/W)
//   crosses_word - 1 when offset + access size runs past the 32-bit word
package lsu_pkg;

  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } lsu_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } lsu_state_e;

  function automatic logic mode_legal(input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ctrl[1:0] carries the size for both signed and unsigned variants.
  function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
    logic [3:0] m;
    case (ctrl[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic crosses_word(input logic [2:0] ctrl, input logic [1:0] off);
    logic c;
    case (ctrl[1:0])
      2'b00:   c = 1'b0;
      2'b01:   c = (off == 2'd3);
      default: c = (off != 2'd0);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data formatter.
//   beat0_i  [31:0] word at the lower address
//   beat1_i  [31:0] word at the next address (0 for single-beat loads)
//   offset_i [1:0]  byte offset of the load address
//   mode_i   [2:0]  access mode (lsu_mode_e encoding)
//   rdata_o  [31:0] right-aligned, sign/zero-extended load data
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] beat0_i,
  input  logic [31:0] beat1_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  mode_i,
  output logic [31:0] rdata_o
);

  logic [31:0] r32;

  // Only the low word of the shifted 64-bit pair is ever needed.
  assign r32 = 32'({beat1_i, beat0_i} >> {offset_i, 3'b000});

  always_comb begin
    rdata_o = r32;
    case (mode_i)
      MODE_B:  rdata_o = {{24{r32[7]}}, r32[7:0]};
      MODE_BU: rdata_o = {24'b0, r32[7:0]};
      MODE_H:  rdata_o = {{16{r32[15]}}, r32[15:0]};
      MODE_HU: rdata_o = {16'b0, r32[15:0]};
      default: rdata_o = r32;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory bus initiator for one load/store at a time.
// Accepts a request when idle, issues word-aligned beats with byte enables,
// waits for grant and response, and returns one formatted response.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             core request handshake (ready only when idle)
//   req_we, req_ctrl, req_addr,     store flag, access mode, byte address,
//   req_wdata                       right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion pulse with data/error
//   mem_req/mem_gnt                 beat request held until granted
//   mem_addr, mem_we, mem_be,       word-aligned beat address, write flag,
//   mem_wdata                       byte enables, lane-shifted store data
//   mem_rvalid, mem_rdata           one response per granted beat
// Parameter TIMEOUT_CYCLES: per-beat wait limit on grant/response (0 = never).
// Build option LSU_MISALIGNED_SPLIT_EN: when defined, word-crossing accesses
// run as two beats; otherwise they complete at once with rsp_err=1.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  // Captured request (data only, never needs reset).
  logic [2:0]       mode_q, mode_d;
  logic             we_q, we_d;
  logic [1:0]       off_q, off_d;

  logic [3:0]       be_lo;
  logic [31:0]      wd_lo;
  logic             tmo;
  logic             bad_req;
  logic [31:0]      align_lo, align_hi, load_data;

  assign be_lo = size_mask(req_ctrl) << req_addr[1:0];
  assign wd_lo = req_wdata << {req_addr[1:0], 3'b000};
  assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TMO_LAST));

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_q, split_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] wd_hi_q, wd_hi_d;
  logic [31:0] beat0_q, beat0_d;
  logic [3:0]  be_hi;
  logic [31:0] wd_hi;

  // Upper halves of the 64-bit lane shift; offset 0 shifts everything out.
  assign be_hi    = size_mask(req_ctrl) >> (3'd4 - {1'b0, req_addr[1:0]});
  assign wd_hi    = req_wdata >> (6'd32 - {1'b0, req_addr[1:0], 3'b000});
  assign bad_req  = !mode_legal(req_ctrl);
  assign align_lo = (state_q == ST_WAIT1) ? beat0_q : mem_rdata;
  assign align_hi = (state_q == ST_WAIT1) ? mem_rdata : 32'b0;
`else
  assign bad_req  = !mode_legal(req_ctrl) || crosses_word(req_ctrl, req_addr[1:0]);
  assign align_lo = mem_rdata;
  assign align_hi = 32'b0;
`endif

  lsu_load_align u_align (
    .beat0_i  (align_lo),
    .beat1_i  (align_hi),
    .offset_i (off_q),
    .mode_i   (mode_q),
    .rdata_o  (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'b0;
    rsp_err_d   = 1'b0;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    mode_d      = mode_q;
    we_d        = we_q;
    off_d       = off_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    split_d     = split_q;
    addr_d      = addr_q;
    be_hi_d     = be_hi_q;
    wd_hi_d     = wd_hi_q;
    beat0_d     = beat0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mode_d = req_ctrl;
          we_d   = req_we;
          off_d  = req_addr[1:0];
          if (bad_req) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ0;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_we_d    = req_we;
            mem_be_d    = be_lo;
            mem_wdata_d = wd_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_d     = crosses_word(req_ctrl, req_addr[1:0]);
            addr_d      = {req_addr[31:2], 2'b00};
            be_hi_d     = be_hi;
            wd_hi_d     = wd_hi;
`endif
          end
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_REQ0, ST_REQ1: begin
`else
      ST_REQ0: begin
`endif
        if (mem_gnt) begin
          state_d = (state_q == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
          cnt_d   = '0;
        end else if (tmo) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_WAIT0, ST_WAIT1: begin
`else
      ST_WAIT0: begin
`endif
        if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (state_q == ST_WAIT0 && split_q) begin
            beat0_d     = mem_rdata;
            state_d     = ST_REQ1;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_addr_d  = addr_q + 32'd4;
            mem_be_d    = be_hi_q;
            mem_wdata_d = wd_hi_q;
          end else
`endif
          begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? 32'b0 : load_data;
          end
        end else if (tmo) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= 32'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q     <= split_d;
`endif
    end
  end

  // Captured request data.
  always_ff @(posedge clk) begin
    mode_q  <= mode_d;
    we_q    <= we_d;
    off_q   <= off_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
    addr_q  <= addr_d;
    be_hi_q <= be_hi_d;
    wd_hi_q <= wd_hi_d;
    beat0_q <= beat0_d;
`endif
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_ctrl   (req_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        bus;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
    logic [31:0] erdata;
    logic        eerr;
    int          gdly;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp_r;
  vec_t tbl[14];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rsp_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic we, input logic [2:0] ctrl,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrd, input logic bus, input logic [31:0] ea,
                              input logic [3:0] ebe, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic eerr, input int gd);
    vec_t v;
    v.name = nm; v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.mrdata = mrd;
    v.bus = bus; v.eaddr = ea; v.ebe = ebe; v.ewdata = ewd; v.erdata = erd; v.eerr = eerr;
    v.gdly = gd;
    return v;
  endfunction

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_prev = 1'b0;
    end else begin
      if (rsp_valid) begin
        check("rsp_pulse_width", {31'b0, rsp_prev}, 32'd0);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rdata=0x%08h err=%0b with nothing outstanding",
                   rsp_rdata, rsp_err);
        end else begin
          exp_r = sb.pop_front();
          check({exp_r.name, "_rdata"}, rsp_rdata, exp_r.rdata);
          check({exp_r.name, "_err"}, {31'b0, rsp_err}, {31'b0, exp_r.err});
        end
      end
      rsp_prev = rsp_valid;
    end
  end

  task automatic send(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_timeout: req_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic serve_beat(input string nm, input logic [31:0] ea, input logic [3:0] ebe,
                            input logic ewe, input logic chk_wd, input logic [31:0] ewd,
                            input logic [31:0] rd, input int gdly);
    int n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_memreq_timeout: mem_req=0, expected 1 within 20 cycles", nm);
      return;
    end
    check({nm, "_addr"}, mem_addr, ea);
    check({nm, "_be"}, {28'b0, mem_be}, {28'b0, ebe});
    check({nm, "_we"}, {31'b0, mem_we}, {31'b0, ewe});
    if (chk_wd) check({nm, "_wdata"}, mem_wdata, ewd);
    if (gdly > 0) begin
      repeat (gdly) @(negedge clk);
      check({nm, "_req_held"}, {31'b0, mem_req}, 32'd1);
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    check({nm, "_req_drop"}, {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic expect_no_bus(input string nm);
    int   n = 0;
    logic saw = 1'b0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      saw |= mem_req;
      n++;
    end
    check({nm, "_no_memreq"}, {31'b0, saw}, 32'd0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_rsp_timeout: %0d responses outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    sb.push_back('{rdata: v.erdata, err: v.eerr, name: v.name});
    send(v.we, v.ctrl, v.addr, v.wdata);
    if (v.bus) serve_beat(v.name, v.eaddr, v.ebe, v.we, v.we, v.ewdata, v.mrdata, v.gdly);
    else       expect_no_bus(v.name);
    drain(v.name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //             name      we  ctrl    addr          wdata         mem rdata     bus mem addr      be       mem wdata     rsp rdata     err gnt dly
    tbl[0]  = mk("lw4",     0, 3'b010, 32'h4,        32'h0,        32'hAABBCCDD, 1, 32'h4,        4'b1111, 32'h0,        32'hAABBCCDD, 0, 0);
    tbl[1]  = mk("lb7",     0, 3'b000, 32'h7,        32'h0,        32'hAABBCCDD, 1, 32'h4,        4'b1000, 32'h0,        32'hFFFFFFAA, 0, 1);
    tbl[2]  = mk("lbu7",    0, 3'b100, 32'h7,        32'h0,        32'hAABBCCDD, 1, 32'h4,        4'b1000, 32'h0,        32'h000000AA, 0, 0);
    tbl[3]  = mk("sh2",     1, 3'b001, 32'h2,        32'h1234ABCD, 32'h0,        1, 32'h0,        4'b1100, 32'hABCD0000, 32'h0,        0, 2);
    tbl[4]  = mk("lh2",     0, 3'b001, 32'h2,        32'h0,        32'h80011234, 1, 32'h0,        4'b1100, 32'h0,        32'hFFFF8001, 0, 0);
    tbl[5]  = mk("lhu2",    0, 3'b101, 32'h2,        32'h0,        32'h80011234, 1, 32'h0,        4'b1100, 32'h0,        32'h00008001, 0, 3);
    tbl[6]  = mk("lb1",     0, 3'b000, 32'h1,        32'h0,        32'h12345678, 1, 32'h0,        4'b0010, 32'h0,        32'h00000056, 0, 0);
    tbl[7]  = mk("lb0pos",  0, 3'b000, 32'h100,      32'h0,        32'hFFFFFF7F, 1, 32'h100,      4'b0001, 32'h0,        32'h0000007F, 0, 0);
    tbl[8]  = mk("sb3",     1, 3'b000, 32'h3,        32'h000000EF, 32'h0,        1, 32'h0,        4'b1000, 32'hEF000000, 32'h0,        0, 1);
    tbl[9]  = mk("sw10",    1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h55555555, 1, 32'h10,       4'b1111, 32'hDEADBEEF, 32'h0,        0, 0);
    tbl[10] = mk("ill011",  0, 3'b011, 32'h4,        32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    tbl[11] = mk("ill111",  1, 3'b111, 32'h8,        32'h12345678, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    tbl[12] = mk("lwtop",   0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h01020304, 1, 32'hFFFFFFFC, 4'b1111, 32'h0,        32'h01020304, 0, 0);
    tbl[13] = mk("lhu0",    0, 3'b101, 32'h0,        32'h0,        32'hCAFE8765, 1, 32'h0,        4'b0011, 32'h0,        32'h00008765, 0, 0);

    // Reset state
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be_we", {27'b0, mem_be, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimum-latency aligned load, cycle by cycle
    sb.push_back('{rdata: 32'hAABBCCDD, err: 1'b0, name: "lat_lw4"});
    send(1'b0, 3'b010, 32'h4, 32'h0);
    @(negedge clk);
    check("lat_req_c1", {31'b0, mem_req}, 32'd1);
    check("lat_addr_c1", mem_addr, 32'h4);
    check("lat_be_c1", {28'b0, mem_be}, 32'hF);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAABBCCDD;
    @(negedge clk);
    check("lat_rsp_c2", {31'b0, rsp_valid}, 32'd0);
    check("lat_req_drop_c2", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("lat_rsp_c3", {31'b0, rsp_valid}, 32'd1);
    drain("lat_lw4");

    // Table-driven single transactions
    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    // Word-crossing accesses
`ifdef LSU_MISALIGNED_SPLIT_EN
    sb.push_back('{rdata: 32'h55443322, err: 1'b0, name: "lw5"});
    send(1'b0, 3'b010, 32'h5, 32'h0);
    serve_beat("lw5_b0", 32'h4, 4'b1110, 1'b0, 1'b0, 32'h0, 32'h44332211, 0);
    serve_beat("lw5_b1", 32'h8, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h88776655, 1);
    drain("lw5");
    sb.push_back('{rdata: 32'h0, err: 1'b0, name: "sw7"});
    send(1'b1, 3'b010, 32'h7, 32'h11223344);
    serve_beat("sw7_b0", 32'h4, 4'b1000, 1'b1, 1'b1, 32'h44000000, 32'h0, 0);
    serve_beat("sw7_b1", 32'h8, 4'b0111, 1'b1, 1'b1, 32'h00112233, 32'h0, 0);
    drain("sw7");
    sb.push_back('{rdata: 32'hFFFFCDAB, err: 1'b0, name: "lhwrap"});
    send(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    serve_beat("lhwrap_b0", 32'hFFFFFFFC, 4'b1000, 1'b0, 1'b0, 32'h0, 32'hAB000000, 0);
    serve_beat("lhwrap_b1", 32'h0, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h000000CD, 0);
    drain("lhwrap");
`else
    sb.push_back('{rdata: 32'h0, err: 1'b1, name: "lw5"});
    send(1'b0, 3'b010, 32'h5, 32'h0);
    expect_no_bus("lw5");
    drain("lw5");
    sb.push_back('{rdata: 32'h0, err: 1'b1, name: "sh3"});
    send(1'b1, 3'b001, 32'h3, 32'hBEEF);
    expect_no_bus("sh3");
    drain("sh3");
`endif

    // Grant never arrives: abort after 16 cycles of mem_req
    sb.push_back('{rdata: 32'h0, err: 1'b1, name: "tmo"});
    send(1'b0, 3'b010, 32'h8, 32'h0);
    n = 0;
    @(negedge clk);
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", n, 32'd16);
    drain("tmo");
    check("tmo_req_low", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADDEAD;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("tmo_stray_ready", {31'b0, req_ready}, 32'd1);

    // Async reset while mem_req is high
    send(1'b0, 3'b010, 32'h4, 32'h0);
    @(negedge clk);
    check("rst_req0_pre", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req0_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_req0_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset in WAIT0, then a stray response, then a clean load
    send(1'b0, 3'b010, 32'h4, 32'h0);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("rst_wait0_busy", {31'b0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait0_ready", {31'b0, req_ready}, 32'd1);
    check("rst_wait0_memreq", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stray_ready", {31'b0, req_ready}, 32'd1);
    run_vec(tbl[0]);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
